// File: rtl/boreal_sram_arb_if.sv
// Bundles the host port, the two vector-engine ports, the SRAM port and error reporting.
// The slave view belongs to the arbiter; the master view belongs to requesters, the SRAM and the error consumer.
interface boreal_sram_arb_if #(
   parameter int unsigned AW = 12
);
   logic          h_req;
   logic          h_wr;
   logic [31:0]   h_addr;
   logic [31:0]   h_wdata;
   logic [3:0]    h_be;
   logic [31:0]   h_rdata;
   logic          h_ack;

   logic          v_rd_req;
   logic [31:0]   v_rd_addr;
   logic [31:0]   v_rd_data;
   logic          v_rd_ack;

   logic          v_wr_req;
   logic [31:0]   v_wr_addr;
   logic [31:0]   v_wr_data;
   logic          v_wr_ack;

   logic          mem_cs;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic          err_clr;
   logic          err_flag;
   logic [31:0]   err_addr;

   modport slave (
      input  h_req, h_wr, h_addr, h_wdata, h_be,
      output h_rdata, h_ack,
      input  v_rd_req, v_rd_addr,
      output v_rd_data, v_rd_ack,
      input  v_wr_req, v_wr_addr, v_wr_data,
      output v_wr_ack,
      output mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata,
      input  err_clr,
      output err_flag, err_addr
   );

   modport master (
      output h_req, h_wr, h_addr, h_wdata, h_be,
      input  h_rdata, h_ack,
      output v_rd_req, v_rd_addr,
      input  v_rd_data, v_rd_ack,
      output v_wr_req, v_wr_addr, v_wr_data,
      input  v_wr_ack,
      input  mem_cs, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata,
      output err_clr,
      input  err_flag, err_addr
   );
endinterface

// File: rtl/boreal_sram_arb.sv
// Three-port round-robin arbiter in front of a single-ported 32-bit SRAM.
// Every access takes a fixed IDLE -> ACCESS -> RESP sequence; out-of-range requests are acked without touching the SRAM.
module boreal_sram_arb #(
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned AW          = 12
) (
   input logic               clk,
   input logic               rst_n,
   boreal_sram_arb_if.slave  bus
);

   localparam int unsigned NPORT = 3;
   localparam int unsigned PW    = 2;

   localparam logic [PW-1:0] P_HOST = PW'(0);
   localparam logic [PW-1:0] P_VRD  = PW'(1);
   localparam logic [PW-1:0] P_VWR  = PW'(2);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] lat_gnt;
   logic          lat_oor;
   logic [31:0]   lat_addr;

   logic [NPORT-1:0] req_vec_c;
   logic [2:0]       scan_c;
   logic [PW-1:0]    gnt_c;
   logic             gnt_vld_c;
   logic [PW-1:0]    next_ptr_c;
   logic             sel_wr_c;
   logic [31:0]      sel_addr_c;
   logic [31:0]      sel_wdata_c;
   logic [3:0]       sel_be_c;
   logic [31:0]      idx_c;
   logic             oor_c;
   logic             err_set_c;

   assign req_vec_c = {bus.v_wr_req, bus.v_rd_req, bus.h_req};

   // Round-robin scan starting at rr_ptr, wrapping mod 3.
   always_comb begin
      gnt_c     = P_HOST;
      gnt_vld_c = 1'b0;
      scan_c    = 3'd0;
      for (int i = 0; i < int'(NPORT); i++) begin
         scan_c = {1'b0, rr_ptr} + 3'(i);
         if (scan_c >= 3'(NPORT)) scan_c = scan_c - 3'(NPORT);
         if (!gnt_vld_c && req_vec_c[scan_c[PW-1:0]]) begin
            gnt_vld_c = 1'b1;
            gnt_c     = scan_c[PW-1:0];
         end
      end
   end

   assign next_ptr_c = (gnt_c == P_VWR) ? P_HOST : gnt_c + PW'(1);

   // Payload of the port about to be granted.
   always_comb begin
      sel_wr_c    = 1'b0;
      sel_addr_c  = 32'h0;
      sel_wdata_c = 32'h0;
      sel_be_c    = 4'h0;
      case (gnt_c)
         P_HOST: begin
            sel_wr_c    = bus.h_wr;
            sel_addr_c  = bus.h_addr;
            sel_wdata_c = bus.h_wdata;
            sel_be_c    = bus.h_be;
         end
         P_VRD: begin
            sel_addr_c  = bus.v_rd_addr;
         end
         P_VWR: begin
            sel_wr_c    = 1'b1;
            sel_addr_c  = bus.v_wr_addr;
            sel_wdata_c = bus.v_wr_data;
            sel_be_c    = 4'hF;
         end
         default: ;
      endcase
   end

   assign idx_c = (sel_addr_c - BASE_ADDR) >> 2;
   assign oor_c = (sel_addr_c < BASE_ADDR) || (idx_c >= 32'(DEPTH_WORDS)) ||
                  (sel_addr_c[1:0] != 2'b00);

   assign err_set_c = (state == ACCESS) && lat_oor;

   // Main FSM; mem_* and ack registers are single-cycle pulses that default low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rr_ptr        <= P_HOST;
         lat_gnt       <= P_HOST;
         lat_oor       <= 1'b0;
         lat_addr      <= 32'h0;
         bus.mem_cs    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= 4'h0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0;
         bus.h_ack     <= 1'b0;
         bus.v_rd_ack  <= 1'b0;
         bus.v_wr_ack  <= 1'b0;
         bus.err_flag  <= 1'b0;
         bus.err_addr  <= 32'h0;
      end else begin
         bus.mem_cs    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= 4'h0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0;
         bus.h_ack     <= 1'b0;
         bus.v_rd_ack  <= 1'b0;
         bus.v_wr_ack  <= 1'b0;

         case (state)
            IDLE: begin
               if (gnt_vld_c) begin
                  state    <= ACCESS;
                  rr_ptr   <= next_ptr_c;
                  lat_gnt  <= gnt_c;
                  lat_oor  <= oor_c;
                  lat_addr <= sel_addr_c;
                  if (!oor_c) begin
                     bus.mem_cs    <= 1'b1;
                     bus.mem_we    <= sel_wr_c;
                     bus.mem_be    <= sel_be_c;
                     bus.mem_addr  <= idx_c[AW-1:0];
                     bus.mem_wdata <= sel_wr_c ? sel_wdata_c : 32'h0;
                  end
               end
            end
            ACCESS: begin
               state        <= RESP;
               bus.h_ack    <= (lat_gnt == P_HOST);
               bus.v_rd_ack <= (lat_gnt == P_VRD);
               bus.v_wr_ack <= (lat_gnt == P_VWR);
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase

         // A new error beats err_clr; only the first address since the last clear is kept.
         if (err_set_c) begin
            bus.err_flag <= 1'b1;
            if (!bus.err_flag || bus.err_clr) bus.err_addr <= lat_addr;
         end else if (bus.err_clr) begin
            bus.err_flag <= 1'b0;
            bus.err_addr <= 32'h0;
         end
      end
   end

   // SRAM read data is only valid in RESP, so it is steered rather than registered.
   always_comb begin
      bus.h_rdata   = 32'h0;
      bus.v_rd_data = 32'h0;
      if ((state == RESP) && !lat_oor) begin
         if (lat_gnt == P_HOST) bus.h_rdata   = bus.mem_rdata;
         if (lat_gnt == P_VRD)  bus.v_rd_data = bus.mem_rdata;
      end
   end

endmodule

// File: tb/tb_boreal_sram_arb.sv
// Directed bench for boreal_sram_arb with a behavioural SRAM behind the memory port.
module tb_boreal_sram_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   boreal_sram_arb_if #(.AW(12)) bus ();

   boreal_sram_arb #(
      .BASE_ADDR  (32'h2000_0000),
      .DEPTH_WORDS(4096),
      .AW         (12)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Behavioural SRAM: one-cycle read latency, byte-enabled writes.
   logic [31:0] sram [0:4095] = '{default: 32'h0};
   logic [31:0] mem_rdata_q = 32'h0;
   assign bus.mem_rdata = mem_rdata_q;

   always @(posedge clk) begin
      if (bus.mem_cs && !bus.mem_we) mem_rdata_q <= sram[bus.mem_addr];
      if (bus.mem_cs && bus.mem_we)
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) sram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start = 0;
   int rem [3];
   int gnt_q [$];
   int ack_cyc_q [$];
   bit cs_seen = 1'b0;
   logic [31:0] last_h_rdata = 32'h0;
   logic [31:0] last_vrd_data = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample #1 after the edge, log acks and retire finished requesters.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_cs) cs_seen = 1'b1;
      if (bus.h_ack) begin
         gnt_q.push_back(0); ack_cyc_q.push_back(cyc); last_h_rdata = bus.h_rdata;
         if (rem[0] > 0) rem[0]--;
         if (rem[0] == 0) bus.h_req = 1'b0;
      end
      if (bus.v_rd_ack) begin
         gnt_q.push_back(1); ack_cyc_q.push_back(cyc); last_vrd_data = bus.v_rd_data;
         if (rem[1] > 0) rem[1]--;
         if (rem[1] == 0) bus.v_rd_req = 1'b0;
      end
      if (bus.v_wr_ack) begin
         gnt_q.push_back(2); ack_cyc_q.push_back(cyc);
         if (rem[2] > 0) rem[2]--;
         if (rem[2] == 0) bus.v_wr_req = 1'b0;
      end
   endtask

   task automatic run_acks(input int n, input int budget);
      int k = 0;
      while (gnt_q.size() < n && k < budget) begin
         step();
         k++;
      end
      check("ack_count", 32'(gnt_q.size()), 32'(n));
   endtask

   task automatic clear_log();
      gnt_q.delete();
      ack_cyc_q.delete();
      cs_seen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.h_req = 0; bus.h_wr = 0; bus.h_addr = 0; bus.h_wdata = 0; bus.h_be = 0;
      bus.v_rd_req = 0; bus.v_rd_addr = 0;
      bus.v_wr_req = 0; bus.v_wr_addr = 0; bus.v_wr_data = 0;
      bus.err_clr = 0;
      for (int i = 0; i < 3; i++) rem[i] = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_h_ack",    32'(bus.h_ack),    32'h0);
      check("rst_v_rd_ack", 32'(bus.v_rd_ack), 32'h0);
      check("rst_v_wr_ack", 32'(bus.v_wr_ack), 32'h0);
      check("rst_mem_cs",   32'(bus.mem_cs),   32'h0);
      check("rst_err_flag", 32'(bus.err_flag), 32'h0);
      check("rst_err_addr", bus.err_addr,      32'h0);
      rst_n = 1'b1;

      // Host write then readback; request issued in the first cycle out of reset.
      clear_log();
      bus.h_wr = 1; bus.h_addr = 32'h2000_0010; bus.h_wdata = 32'hA5A5_1234; bus.h_be = 4'b0011;
      bus.h_req = 1; rem[0] = 1; start = cyc;
      step();
      check("wr_mem_cs",    32'(bus.mem_cs),   32'h1);
      check("wr_mem_we",    32'(bus.mem_we),   32'h1);
      check("wr_mem_addr",  32'(bus.mem_addr), 32'h4);
      check("wr_mem_be",    32'(bus.mem_be),   32'h3);
      check("wr_mem_wdata", bus.mem_wdata,     32'hA5A5_1234);
      check("wr_ack_early", 32'(bus.h_ack),    32'h0);
      run_acks(1, 4);
      check("wr_ack_lat", 32'(ack_cyc_q[0] - start), 32'h2);
      step();

      clear_log();
      bus.h_wr = 0; bus.h_be = 4'h0; bus.h_req = 1; rem[0] = 1; start = cyc;
      step();
      check("rd_mem_cs",   32'(bus.mem_cs),   32'h1);
      check("rd_mem_we",   32'(bus.mem_we),   32'h0);
      check("rd_mem_addr", 32'(bus.mem_addr), 32'h4);
      run_acks(1, 4);
      check("rd_ack_lat", 32'(ack_cyc_q[0] - start), 32'h2);
      check("rd_data_lo", {16'h0, last_h_rdata[15:0]}, 32'h0000_1234);
      step();

      // Vector read and write raised together.
      clear_log();
      bus.v_rd_addr = 32'h2000_0010;
      bus.v_wr_addr = 32'h2000_0020; bus.v_wr_data = 32'hDEAD_BEEF;
      bus.v_rd_req = 1; bus.v_wr_req = 1; rem[1] = 1; rem[2] = 1; start = cyc;
      run_acks(2, 12);
      check("vv_first",   32'(gnt_q[0]), 32'h1);
      check("vv_second",  32'(gnt_q[1]), 32'h2);
      check("vv_rd_lat",  32'(ack_cyc_q[0] - start), 32'h2);
      check("vv_gap",     32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'h3);
      check("vv_rd_data", last_vrd_data, 32'h0000_1234);
      step();

      // All three held for nine accesses.
      clear_log();
      bus.h_wr = 0; bus.h_addr = 32'h2000_0020;
      bus.v_rd_addr = 32'h2000_0010;
      bus.v_wr_addr = 32'h2000_0024; bus.v_wr_data = 32'hCAFE_0001;
      bus.h_req = 1; bus.v_rd_req = 1; bus.v_wr_req = 1;
      rem[0] = 3; rem[1] = 3; rem[2] = 3;
      run_acks(9, 40);
      for (int i = 0; i < 9; i++) check($sformatf("rr_order_%0d", i), 32'(gnt_q[i]), 32'(i % 3));
      check("rr_span",   32'(ack_cyc_q[8] - ack_cyc_q[0]), 32'd24);
      check("rr_h_data", last_h_rdata, 32'hDEAD_BEEF);
      step();

      // Out-of-range vector read (index 4096).
      clear_log();
      bus.v_rd_addr = 32'h2000_4000; bus.v_rd_req = 1; rem[1] = 1; start = cyc;
      run_acks(1, 6);
      check("oor1_port",  32'(gnt_q[0]), 32'h1);
      check("oor1_lat",   32'(ack_cyc_q[0] - start), 32'h2);
      check("oor1_nocs",  32'(cs_seen), 32'h0);
      check("oor1_data",  last_vrd_data, 32'h0);
      step();
      check("oor1_flag",  32'(bus.err_flag), 32'h1);
      check("oor1_addr",  bus.err_addr, 32'h2000_4000);

      // Second error below the base keeps the first address.
      clear_log();
      bus.h_wr = 0; bus.h_addr = 32'h1FFF_FFFC; bus.h_req = 1; rem[0] = 1; start = cyc;
      run_acks(1, 6);
      check("oor2_port", 32'(gnt_q[0]), 32'h0);
      check("oor2_lat",  32'(ack_cyc_q[0] - start), 32'h2);
      check("oor2_data", last_h_rdata, 32'h0);
      check("oor2_nocs", 32'(cs_seen), 32'h0);
      step();
      check("oor2_flag", 32'(bus.err_flag), 32'h1);
      check("oor2_addr", bus.err_addr, 32'h2000_4000);

      // Misaligned write with err_clr in the same cycle the error is recorded.
      clear_log();
      bus.h_wr = 1; bus.h_addr = 32'h2000_0002; bus.h_wdata = 32'hFFFF_FFFF; bus.h_be = 4'hF;
      bus.h_req = 1; rem[0] = 1;
      step();
      bus.err_clr = 1;
      step();
      bus.err_clr = 0;
      run_acks(1, 4);
      step();
      check("oor3_flag", 32'(bus.err_flag), 32'h1);
      check("oor3_addr", bus.err_addr, 32'h2000_0002);
      check("oor3_nocs", 32'(cs_seen), 32'h0);

      bus.err_clr = 1;
      step();
      bus.err_clr = 0;
      check("clr_flag", 32'(bus.err_flag), 32'h0);
      check("clr_addr", bus.err_addr, 32'h0);

      // Reset asserted while a host write is in ACCESS.
      clear_log();
      bus.h_wr = 1; bus.h_addr = 32'h2000_0030; bus.h_wdata = 32'h1111_2222; bus.h_be = 4'hF;
      bus.h_req = 1; rem[0] = 1;
      step();
      check("ra_mem_cs", 32'(bus.mem_cs), 32'h1);
      rst_n = 1'b0;
      bus.h_req = 0;
      #1;
      check("ra_h_ack",     32'(bus.h_ack),    32'h0);
      check("ra_v_rd_ack",  32'(bus.v_rd_ack), 32'h0);
      check("ra_v_wr_ack",  32'(bus.v_wr_ack), 32'h0);
      check("ra_mem_cs0",   32'(bus.mem_cs),   32'h0);
      check("ra_mem_we",    32'(bus.mem_we),   32'h0);
      check("ra_mem_be",    32'(bus.mem_be),   32'h0);
      check("ra_mem_addr",  32'(bus.mem_addr), 32'h0);
      check("ra_mem_wdata", bus.mem_wdata,     32'h0);
      check("ra_h_rdata",   bus.h_rdata,       32'h0);
      check("ra_v_rd_data", bus.v_rd_data,     32'h0);
      check("ra_err_flag",  32'(bus.err_flag), 32'h0);
      check("ra_err_addr",  bus.err_addr,      32'h0);
      step();
      step();
      check("ra_no_ack", 32'(gnt_q.size()), 32'h0);

      // Host and vector read together out of reset: rr_ptr must be back at P0.
      clear_log();
      rst_n = 1'b1;
      bus.h_wr = 0; bus.h_addr = 32'h2000_0030; bus.h_be = 4'h0;
      bus.v_rd_addr = 32'h2000_0020;
      bus.h_req = 1; bus.v_rd_req = 1; rem[0] = 1; rem[1] = 1; start = cyc;
      run_acks(2, 12);
      check("pr_first",  32'(gnt_q[0]), 32'h0);
      check("pr_second", 32'(gnt_q[1]), 32'h1);
      check("pr_lat",    32'(ack_cyc_q[0] - start), 32'h2);
      check("pr_h_data", last_h_rdata, 32'h0);
      check("pr_v_data", last_vrd_data, 32'hDEAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
